// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus reader: state encodings, register map
// and the update command written ahead of a sweep when that option is built in.
package rtc_pkg;

  localparam int SLOT_COUNT = 11;
  localparam logic [3:0] LAST_SLOT = 4'(SLOT_COUNT - 1);

  localparam logic [7:0] RTC_CMD_ADDR   = 8'hF0;
  localparam logic [7:0] RTC_CMD_UPDATE = 8'hF0;

  // Slot order: sec, min, hour, date, month, year, dow, week, tmr sec/min/hour
  localparam logic [7:0] RTC_ADDR_TABLE [SLOT_COUNT] = '{
    8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
    8'h27, 8'h28, 8'h41, 8'h42, 8'h43
  };

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_ADDR_SETUP,
    PH_ADDR_STROBE,
    PH_ADDR_HOLD,
    PH_TURN,
    PH_DATA_STROBE,
    PH_DATA_END
  } phase_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CMD,
    SEQ_READ,
    SEQ_COMMIT
  } seq_e;

  function automatic logic [7:0] slot_addr(input logic [3:0] slot);
    logic [7:0] addr;
    addr = 8'h00;
    if (slot <= LAST_SLOT) addr = RTC_ADDR_TABLE[slot];
    return addr;
  endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// One multiplexed-bus access to the RTC: six equal-length phases, pins
// registered from the next phase so no decode logic reaches a pad.
//
// state           | meaning
// PH_IDLE         | bus parked, waiting for go_i
// PH_ADDR_SETUP   | address driven, a_d=0, strobes high
// PH_ADDR_STROBE  | address latched by chip (cs_n/wr_n low)
// PH_ADDR_HOLD    | strobes released, address still driven
// PH_TURN         | a_d=1; read: bus floats, write: data set up
// PH_DATA_STROBE  | cs_n low with rd_n (read) or wr_n (write)
// PH_DATA_END     | strobes released; may chain straight into next access
module rtc_bus_phase
  import rtc_pkg::*;
#(
  parameter int T_PHASE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go_i,
  input  logic [7:0] addr_i,
  input  logic       wr_sel_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] ad_out_o,
  output logic       ad_oe_o,
  output logic       cs_n_o,
  output logic       rd_n_o,
  output logic       wr_n_o,
  output logic       a_d_o,
  output logic       sample_o,
  output logic       acc_done_o
);

  phase_e     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a_d_q, a_d_d;
  logic       last;

  assign last = (cnt_q == 8'(T_PHASE - 1));

  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    ad_out_d = ad_out_q;

    if (phase_q != PH_IDLE) cnt_d = last ? 8'd0 : cnt_q + 8'd1;

    case (phase_q)
      PH_IDLE:        if (go_i) phase_d = PH_ADDR_SETUP;
      PH_ADDR_SETUP:  if (last) phase_d = PH_ADDR_STROBE;
      PH_ADDR_STROBE: if (last) phase_d = PH_ADDR_HOLD;
      PH_ADDR_HOLD:   if (last) phase_d = PH_TURN;
      PH_TURN:        if (last) phase_d = PH_DATA_STROBE;
      PH_DATA_STROBE: if (last) phase_d = PH_DATA_END;
      PH_DATA_END:    if (last) phase_d = go_i ? PH_ADDR_SETUP : PH_IDLE;
      default:        phase_d = PH_IDLE;
    endcase

    if (go_i && (phase_q == PH_IDLE || (phase_q == PH_DATA_END && last))) begin
      wr_d     = wr_sel_i;
      ad_out_d = addr_i;
    end
    if (phase_q == PH_ADDR_HOLD && last && wr_q) ad_out_d = wdata_i;

    a_d_d   = 1'b1;
    ad_oe_d = 1'b0;
    cs_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    wr_n_d  = 1'b1;
    case (phase_d)
      PH_ADDR_SETUP, PH_ADDR_HOLD: begin
        a_d_d   = 1'b0;
        ad_oe_d = 1'b1;
      end
      PH_ADDR_STROBE: begin
        a_d_d   = 1'b0;
        ad_oe_d = 1'b1;
        cs_n_d  = 1'b0;
        wr_n_d  = 1'b0;
      end
      PH_TURN, PH_DATA_END: ad_oe_d = wr_d;
      PH_DATA_STROBE: begin
        ad_oe_d = wr_d;
        cs_n_d  = 1'b0;
        rd_n_d  = wr_d;
        wr_n_d  = ~wr_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= 8'd0;
      wr_q     <= 1'b0;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_d_q    <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      a_d_q    <= a_d_d;
    end
  end

  assign ad_out_o   = ad_out_q;
  assign ad_oe_o    = ad_oe_q;
  assign cs_n_o     = cs_n_q;
  assign rd_n_o     = rd_n_q;
  assign wr_n_o     = wr_n_q;
  assign a_d_o      = a_d_q;
  assign sample_o   = (phase_q == PH_DATA_STROBE) && last && !wr_q;
  assign acc_done_o = (phase_q == PH_DATA_END) && last;

endmodule

// File: rtl/rtc_bus_reader.sv
// Sweeps the eleven RTC registers into shadow storage and commits them in one
// cycle. Define RTC_BUS_READER_UPDATE_CMD_EN to prefix each sweep with the update-command write.
//
// state      | meaning
// SEQ_IDLE   | waiting for start
// SEQ_CMD    | writing the transfer-update command
// SEQ_READ   | reading slot slot_q
// SEQ_COMMIT | shadow copied to datos, done pulsed
module rtc_bus_reader
  import rtc_pkg::*;
#(
  parameter int T_PHASE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       busy,
  output logic       done,
  output logic [7:0] datos0,
  output logic [7:0] datos1,
  output logic [7:0] datos2,
  output logic [7:0] datos3,
  output logic [7:0] datos4,
  output logic [7:0] datos5,
  output logic [7:0] datos6,
  output logic [7:0] datos7,
  output logic [7:0] datos8,
  output logic [7:0] datos9,
  output logic [7:0] datos10
);

`ifdef RTC_BUS_READER_UPDATE_CMD_EN
  localparam bit CMD_EN = 1'b1;
`else
  localparam bit CMD_EN = 1'b0;
`endif

  seq_e       state_q, state_d;
  logic [3:0] slot_q, slot_d;
  logic       busy_q, done_q;
  logic [7:0] shadow_q [SLOT_COUNT];
  logic [7:0] datos_q  [SLOT_COUNT];

  logic       go;
  logic [7:0] acc_addr;
  logic       acc_wr;
  logic       sample;
  logic       acc_done;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    go       = 1'b0;
    acc_addr = slot_addr(slot_q);
    acc_wr   = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          go     = 1'b1;
          slot_d = 4'd0;
          if (CMD_EN) begin
            state_d  = SEQ_CMD;
            acc_addr = RTC_CMD_ADDR;
            acc_wr   = 1'b1;
          end else begin
            state_d  = SEQ_READ;
            acc_addr = slot_addr(4'd0);
          end
        end
      end
      SEQ_CMD: begin
        if (acc_done) begin
          go       = 1'b1;
          state_d  = SEQ_READ;
          acc_addr = slot_addr(4'd0);
        end
      end
      SEQ_READ: begin
        if (acc_done) begin
          if (slot_q == LAST_SLOT) begin
            state_d = SEQ_COMMIT;
          end else begin
            go       = 1'b1;
            slot_d   = slot_q + 4'd1;
            acc_addr = slot_addr(slot_q + 4'd1);
          end
        end
      end
      SEQ_COMMIT: state_d = SEQ_IDLE;
      default:    state_d = SEQ_IDLE;
    endcase
  end

  // Commit loads on entry so datos and done appear together in the COMMIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      slot_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < SLOT_COUNT; i++) begin
        shadow_q[i] <= 8'h00;
        datos_q[i]  <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      busy_q  <= (state_d != SEQ_IDLE);
      done_q  <= (state_d == SEQ_COMMIT);
      if (sample && state_q == SEQ_READ) shadow_q[slot_q] <= ad_in;
      if (state_d == SEQ_COMMIT) begin
        for (int i = 0; i < SLOT_COUNT; i++) datos_q[i] <= shadow_q[i];
      end
    end
  end

  rtc_bus_phase #(
    .T_PHASE (T_PHASE)
  ) u_phase (
    .clk        (clk),
    .reset      (reset),
    .go_i       (go),
    .addr_i     (acc_addr),
    .wr_sel_i   (acc_wr),
    .wdata_i    (RTC_CMD_UPDATE),
    .ad_out_o   (ad_out),
    .ad_oe_o    (ad_oe),
    .cs_n_o     (cs_n),
    .rd_n_o     (rd_n),
    .wr_n_o     (wr_n),
    .a_d_o      (a_d),
    .sample_o   (sample),
    .acc_done_o (acc_done)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign datos0  = datos_q[0];
  assign datos1  = datos_q[1];
  assign datos2  = datos_q[2];
  assign datos3  = datos_q[3];
  assign datos4  = datos_q[4];
  assign datos5  = datos_q[5];
  assign datos6  = datos_q[6];
  assign datos7  = datos_q[7];
  assign datos8  = datos_q[8];
  assign datos9  = datos_q[9];
  assign datos10 = datos_q[10];

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Bench for rtc_bus_reader: RTC bus model answering addr^key, protocol monitor,
// and a scoreboard of expected datos bytes pushed at each start.
module tb_rtc_bus_reader;

  localparam int T = 10;
`ifdef RTC_BUS_READER_UPDATE_CMD_EN
  localparam bit CMD = 1'b1;
`else
  localparam bit CMD = 1'b0;
`endif
  localparam int N_ACC = CMD ? 12 : 11;
  localparam int LAT   = 6 * N_ACC * T + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, done;
  logic [7:0] datos0, datos1, datos2, datos3, datos4, datos5;
  logic [7:0] datos6, datos7, datos8, datos9, datos10;
  logic [7:0] datos_w [11];

  always #5 clk = ~clk;

  rtc_bus_reader #(.T_PHASE(T)) dut (
    .clk(clk), .reset(reset), .start(start), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .a_d(a_d), .busy(busy), .done(done),
    .datos0(datos0), .datos1(datos1), .datos2(datos2), .datos3(datos3),
    .datos4(datos4), .datos5(datos5), .datos6(datos6), .datos7(datos7),
    .datos8(datos8), .datos9(datos9), .datos10(datos10)
  );

  assign datos_w[0]  = datos0;
  assign datos_w[1]  = datos1;
  assign datos_w[2]  = datos2;
  assign datos_w[3]  = datos3;
  assign datos_w[4]  = datos4;
  assign datos_w[5]  = datos5;
  assign datos_w[6]  = datos6;
  assign datos_w[7]  = datos7;
  assign datos_w[8]  = datos8;
  assign datos_w[9]  = datos9;
  assign datos_w[10] = datos10;

  logic [7:0] rtc_map [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                              8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RTC model: latch address on the address strobe, return addr^key while rd_n low
  logic [7:0] lat_addr = 8'h00;
  logic [7:0] key = 8'h00;
  assign ad_in = !rd_n ? (lat_addr ^ key) : 8'hEE;
  always @(posedge clk) if (!cs_n && !wr_n && !a_d) lat_addr <= ad_out;

  int         run = 0, n_strobes = 0, bad_len = 0, bad_ovl = 0, bad_bus = 0, wr_data_cyc = 0;
  bit         rec_first = 1'b0;
  logic [7:0] first_addr = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      run = 0;
    end else begin
      if (!cs_n) run++;
      else if (run > 0) begin
        n_strobes++;
        if (run != T) bad_len++;
        run = 0;
      end
      if (ad_oe && !rd_n) bad_ovl++;
      if (!cs_n && !wr_n && !a_d && !ad_oe) bad_bus++;
      if (!cs_n && rd_n && wr_n) bad_bus++;
      if (!wr_n && a_d) begin
        wr_data_cyc++;
        if (!ad_oe || ad_out !== 8'hF0) bad_bus++;
      end
      if (rec_first && !cs_n && !wr_n && !a_d) begin
        first_addr = ad_out;
        rec_first  = 1'b0;
      end
    end
  end

  logic [7:0] exp_q [$];

  // Caller is #1 after an edge with the DUT idle. Returns #1 after the cycle following COMMIT.
  task automatic sweep(input logic [7:0] k, input int pa, input int pb, input bit poke);
    int         first, cnt, bad_hold, s0, w0;
    bit         fin;
    logic [7:0] prev [11];
    logic [7:0] e;
    key = k;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(rtc_map[i] ^ k);
      prev[i] = datos_w[i];
    end
    s0 = n_strobes;
    w0 = wr_data_cyc;
    rec_first = 1'b1;
    first = -1; cnt = 0; bad_hold = 0; fin = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= LAT + 50 && !fin; n++) begin
      @(posedge clk); #1;
      start = (n == pa || n == pb);
      if (done) cnt++;
      if (first >= 0) begin
        if (poke) check("start_in_commit_busy", busy, 0);
        fin = 1'b1;
      end else if (done) begin
        first = n;
        for (int i = 0; i < 11; i++) begin
          e = exp_q.pop_front();
          check($sformatf("datos%0d", i), datos_w[i], e);
        end
        if (poke) start = 1'b1;
      end else begin
        for (int i = 0; i < 11; i++) if (datos_w[i] !== prev[i]) bad_hold++;
      end
    end
    start = 1'b0;
    if (first < 0) begin
      for (int i = 0; i < 11; i++) void'(exp_q.pop_front());
    end
    check("latency", first, LAT);
    check("done_count", cnt, 1);
    check("datos_hold", bad_hold, 0);
    check("strobes", n_strobes - s0, 2 * N_ACC);
    check("wr_data_cycles", wr_data_cyc - w0, CMD ? T : 0);
    check("first_addr", first_addr, CMD ? 8'hF0 : 8'h21);
    check("strobe_len_err", bad_len, 0);
    check("oe_rd_overlap", bad_ovl, 0);
    check("bus_err", bad_bus, 0);
  endtask

  task automatic check_reset_pins(input string pfx);
    check({pfx, "_ad_out"}, ad_out, 8'h00);
    check({pfx, "_ad_oe"}, ad_oe, 0);
    check({pfx, "_cs_n"}, cs_n, 1);
    check({pfx, "_rd_n"}, rd_n, 1);
    check({pfx, "_wr_n"}, wr_n, 1);
    check({pfx, "_a_d"}, a_d, 1);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    for (int i = 0; i < 11; i++) check($sformatf("%s_datos%0d", pfx, i), datos_w[i], 8'h00);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    sweep(8'h10, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    sweep(8'h5A, 5, 300, 1'b1);
    sweep(8'hA5, 0, 0, 1'b0);

    // Abort a sweep with reset; the aborted sweep pushes nothing to the scoreboard.
    key = 8'h33;
    start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_reset_pins("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < LAT + 50; n++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check("done_after_abort", cnt, 0);
    check("busy_after_abort", busy, 0);
    sweep(8'hC3, 0, 0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
